// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, data width and the arbiter FSM
// state encoding used by alu and alu_arbiter.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// Single-cycle ALU: AND/OR/ADD/SUB on 32-bit operands with a Zero flag that
// is only raised by SUB of equal operands.
module alu
  import alu_pkg::*;
(
  input  logic [1:0]      alu_control,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] alu_result,
  output logic            zero
);

  // NOTE: every signal driven from always_comb gets a default first so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    alu_result = '0;
    unique case (alu_control)
      ALU_AND: alu_result = a & b;
      ALU_OR:  alu_result = a | b;
      ALU_ADD: alu_result = a + b;
      ALU_SUB: alu_result = a - b;
      default: alu_result = '0;
    endcase
  end

  // A zero AND/OR/ADD result deliberately leaves the flag low.
  assign zero = (alu_control == ALU_SUB) && (alu_result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters: capture the granted
// operation, execute it for one cycle, hold the registered result until taken.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int RR_INIT = 0
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [1:0]      req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_result,
  output logic            rsp0_zero,

  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [1:0]      req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_result,
  output logic            rsp1_zero
);

  localparam logic PRIO_INIT = (RR_INIT != 0);

  state_t          state_q, state_d;
  logic            prio_q;
  logic            gnt_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] res_q;
  logic            zero_q;
  logic            rsp0_valid_q, rsp1_valid_q;

  logic            grant;
  logic            sel;
  logic            rsp_accept;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;

  // Grant decision: a lone requester wins outright, a tie goes to prio_q.
  // Gated by rst_n so the ready outputs drop the instant reset is asserted.
  always_comb begin
    grant = 1'b0;
    sel   = 1'b0;
    if (rst_n && state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant = 1'b1;
        sel   = prio_q;
      end else if (req0_valid) begin
        grant = 1'b1;
        sel   = 1'b0;
      end else if (req1_valid) begin
        grant = 1'b1;
        sel   = 1'b1;
      end
    end
  end

  assign req0_ready = grant && !sel;
  assign req1_ready = grant &&  sel;

  // Only the granted requester's response handshake is observed.
  assign rsp_accept = (state_q == RESP) && (gnt_q ? rsp1_ready : rsp0_ready);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the operand latches are reset along with the control state so the
  // ALU input, and therefore every output, is fully defined out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q       <= PRIO_INIT;
      gnt_q        <= 1'b0;
      op_q         <= ALU_AND;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      zero_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      if (grant) begin
        gnt_q <= sel;
        op_q  <= sel ? req1_op : req0_op;
        a_q   <= sel ? req1_a  : req0_a;
        b_q   <= sel ? req1_b  : req0_b;
      end
      if (state_q == EXEC) begin
        res_q        <= alu_result;
        zero_q       <= alu_zero;
        rsp0_valid_q <= !gnt_q;
        rsp1_valid_q <=  gnt_q;
      end
      if (rsp_accept) begin
        prio_q       <= !gnt_q;
        rsp0_valid_q <= 1'b0;
        rsp1_valid_q <= 1'b0;
      end
    end
  end

  alu u_alu (
    .alu_control (op_q),
    .a           (a_q),
    .b           (b_q),
    .alu_result  (alu_result),
    .zero        (alu_zero)
  );

  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_result = res_q;
  assign rsp1_result = res_q;
  assign rsp0_zero   = zero_q;
  assign rsp1_zero   = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized
// traffic compared against an arithmetic reference and a round-robin model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero;

  int checks = 0;
  int errors = 0;
  bit prio_m;

  alu_arbiter #(.RR_INIT(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_op     (req0_op),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_result (rsp0_result),
    .rsp0_zero   (rsp0_zero),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_op     (req1_op),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_result (rsp1_result),
    .rsp1_zero   (rsp1_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference ALU: {zero, result}. Zero only for SUB of equal operands.
  function automatic logic [32:0] ref_alu(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    case (op)
      2'd0:    r = a & b;
      2'd1:    r = a | b;
      2'd2:    r = a + b;
      default: r = a - b;
    endcase
    return {(op == 2'd3) && (a == b), r};
  endfunction

  task automatic clear_inputs();
    req0_valid = 1'b0; req0_op = 2'd0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = 2'd0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prio_m = 1'b0;
  endtask

  // One transaction: drives both request ports, predicts the winner from the
  // round-robin model and checks handshake timing and the response contents.
  task automatic run_op(input bit rv0, input bit rv1,
                        input logic [1:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [1:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                        input int hold);
    bit          w;
    logic [32:0] exp;
    logic        got_v, oth_v, got_z;
    logic [31:0] got_r;
    w   = (rv0 && rv1) ? prio_m : rv1;
    exp = w ? ref_alu(op1, a1, b1) : ref_alu(op0, a0, b0);
    @(negedge clk);
    req0_valid = rv0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = rv1; req1_op = op1; req1_a = a1; req1_b = b1;
    #1;
    checks++;
    if (req0_ready !== !w || req1_ready !== w) begin
      errors++;
      $display("FAIL grant: ready0=%b ready1=%b expected winner %0d", req0_ready, req1_ready, w);
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    checks++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      errors++;
      $display("FAIL exec_no_rsp: rsp0_valid=%b rsp1_valid=%b expected 0 0", rsp0_valid, rsp1_valid);
    end
    @(negedge clk); #1;
    got_v = w ? rsp1_valid : rsp0_valid;
    oth_v = w ? rsp0_valid : rsp1_valid;
    got_r = w ? rsp1_result : rsp0_result;
    got_z = w ? rsp1_zero : rsp0_zero;
    checks++;
    if (got_v !== 1'b1 || oth_v !== 1'b0) begin
      errors++;
      $display("FAIL rsp_valid: granted=%b other=%b expected 1 0 (req %0d)", got_v, oth_v, w);
    end
    checks++;
    if ({got_z, got_r} !== exp) begin
      errors++;
      $display("FAIL rsp_data: result=%h zero=%b expected result=%h zero=%b",
               got_r, got_z, exp[31:0], exp[32]);
    end
    // Asserting the non-granted rsp_ready while stalled must be ignored.
    if (w) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      got_v = w ? rsp1_valid : rsp0_valid;
      got_r = w ? rsp1_result : rsp0_result;
      got_z = w ? rsp1_zero : rsp0_zero;
      checks++;
      if (got_v !== 1'b1 || {got_z, got_r} !== exp) begin
        errors++;
        $display("FAIL rsp_hold: valid=%b result=%h zero=%b expected 1 %h %b",
                 got_v, got_r, got_z, exp[31:0], exp[32]);
      end
    end
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    if (w) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    checks++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      errors++;
      $display("FAIL rsp_release: rsp0_valid=%b rsp1_valid=%b expected 0 0", rsp0_valid, rsp1_valid);
    end
    prio_m = !w;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero} !== 6'b0 ||
        rsp0_result !== 32'h0 || rsp1_result !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b%b vld=%b%b res=%h/%h zero=%b%b expected all 0",
               req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_result, rsp1_result,
               rsp0_zero, rsp1_zero);
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    prio_m = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    run_op(1'b1, 1'b0, 2'b10, 32'd5, 32'd7, 2'b00, 32'd0, 32'd0, 0);
    run_op(1'b0, 1'b1, 2'b11, 32'h1234, 32'h1234, 2'b00, 32'd0, 32'd0, 0);
    run_op(1'b0, 1'b1, 2'b00, 32'd0, 32'd0, 2'b00, 32'hF0F0, 32'h0F0F, 1);
  endtask

  task automatic test_wrap();
    run_op(1'b1, 1'b0, 2'b10, 32'hFFFF_FFFF, 32'd1, 2'b00, 32'd0, 32'd0, 0);
    run_op(1'b0, 1'b1, 2'b00, 32'd0, 32'd0, 2'b11, 32'd0, 32'd1, 0);
    run_op(1'b1, 1'b0, 2'b01, 32'h0, 32'h0, 2'b00, 32'd0, 32'd0, 0);
  endtask

  task automatic test_back_to_back();
    int gnt_who[4];
    int gnt_cyc[4];
    int n;
    do_reset();
    @(negedge clk);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 2'b10; req0_a = $urandom; req0_b = $urandom;
    req1_valid = 1'b1; req1_op = 2'b11; req1_a = $urandom; req1_b = $urandom;
    n = 0;
    for (int c = 0; c < 30 && n < 4; c++) begin
      #1;
      checks++;
      if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
        errors++;
        $display("FAIL both_ready: cycle %0d ready0=1 ready1=1 expected at most one", c);
      end
      if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
        gnt_who[n] = (req1_ready === 1'b1) ? 1 : 0;
        gnt_cyc[n] = c;
        n++;
      end
      @(negedge clk);
      if (n > 0 && gnt_cyc[n-1] == c) begin
        if (gnt_who[n-1] == 1) begin req1_a = $urandom; req1_b = $urandom; end
        else begin req0_a = $urandom; req0_b = $urandom; end
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL rr_count: got %0d grants within 30 cycles expected 4", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (gnt_who[i] != (i % 2)) begin
        errors++;
        $display("FAIL rr_order: grant %0d went to %0d expected %0d", i, gnt_who[i], i % 2);
      end
      if (i > 0) begin
        checks++;
        if (gnt_cyc[i] - gnt_cyc[i-1] != 3) begin
          errors++;
          $display("FAIL rr_spacing: grant %0d gap %0d cycles expected 3", i, gnt_cyc[i] - gnt_cyc[i-1]);
        end
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 2'b11; req0_a = 32'd9; req0_b = 32'd4;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_grant0: req0_ready=%b expected 1", req0_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = 2'b01; req1_a = 32'h0000_00FF; req1_b = 32'h0000_FF00;
    @(negedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd5 || rsp0_zero !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall: cycle %0d valid=%b result=%h zero=%b req1_ready=%b expected 1 00000005 0 0",
                 i, rsp0_valid, rsp0_result, rsp0_zero, req1_ready);
      end
      @(negedge clk); #1;
    end
    rsp0_ready = 1'b1;
    #1;
    checks++;
    if (req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_comb_path: req1_ready=%b expected 0 while rsp0_ready rises", req1_ready);
    end
    @(negedge clk);
    rsp0_ready = 1'b0;
    #1;
    checks++;
    if (req1_ready !== 1'b1 || rsp0_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_grant1: req1_ready=%b rsp0_valid=%b expected 1 0", req1_ready, rsp0_valid);
    end
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (rsp1_valid !== 1'b1 || rsp1_result !== 32'h0000_FFFF || rsp1_zero !== 1'b0) begin
      errors++;
      $display("FAIL bp_rsp1: valid=%b result=%h zero=%b expected 1 0000ffff 0",
               rsp1_valid, rsp1_result, rsp1_zero);
    end
    rsp1_ready = 1'b1;
    @(negedge clk);
    rsp1_ready = 1'b0;
    prio_m = 1'b0;
  endtask

  task automatic test_reset_exec();
    do_reset();
    run_op(1'b1, 1'b0, 2'b10, 32'd100, 32'd23, 2'b00, 32'd0, 32'd0, 0);
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 2'b01; req0_a = 32'hAAAA_0000; req0_b = 32'h0000_5555;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL rx_grant: req0_ready=%b expected 1", req0_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero} !== 6'b0 ||
        rsp0_result !== 32'h0 || rsp1_result !== 32'h0) begin
      errors++;
      $display("FAIL rx_async: rdy=%b%b vld=%b%b res=%h/%h zero=%b%b expected all 0",
               req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_result, rsp1_result,
               rsp0_zero, rsp1_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    prio_m = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
        errors++;
        $display("FAIL rx_no_rsp: cycle %0d rsp0_valid=%b rsp1_valid=%b expected 0 0",
                 i, rsp0_valid, rsp1_valid);
      end
    end
    run_op(1'b1, 1'b1, 2'b10, 32'd1, 32'd2, 2'b10, 32'd3, 32'd4, 0);
  endtask

  task automatic test_random();
    logic [1:0]  v;
    logic [1:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      v   = 2'($urandom_range(1, 3));
      op0 = 2'($urandom_range(0, 3));
      op1 = 2'($urandom_range(0, 3));
      a0  = $urandom; b0 = $urandom;
      a1  = $urandom; b1 = $urandom;
      if ($urandom_range(0, 3) == 0) b0 = a0;
      if ($urandom_range(0, 3) == 0) b1 = a1;
      run_op(v[0], v[1], op0, a0, b0, op1, a1, b1, $urandom_range(0, 3));
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    prio_m = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_reset_exec();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle `ALU` (AND/OR/ADD/SUB, 2-bit op, `Zero` flag) between two independent requesters, for example the main pipeline and a multi-cycle helper unit. Round-robin arbitration selects one requester at a time. The block captures that requester's operands, drives the ALU for one cycle, and holds the registered result until the requester accepts it. It sits beside the datapath and is the only block that drives the shared ALU instance.

## Interface
- `RR_INIT`, default 0: requester that holds priority after reset (0 or 1).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req0_valid`  in  1  requester 0 presents an operation.
- `req0_ready`  out  1  requester 0's operation is accepted this cycle.
- `req0_op`  in  2  ALU control: 00 AND, 01 OR, 10 ADD, 11 SUB.
- `req0_a`, `req0_b`  in  32  operands.
- `rsp0_valid`  out  1  result for requester 0 is available.
- `rsp0_ready`  in  1  requester 0 accepts the result.
- `rsp0_result`  out  32  ALU result.
- `rsp0_zero`  out  1  ALU Zero flag.
- `req1_*` / `rsp1_*`: identical set for requester 1.

## Operation
- The FSM has three states: IDLE, EXEC and RESP.
- **IDLE:**
  - If neither valid is high, stay in IDLE.
  - If exactly one valid is high, grant that requester regardless of priority.
  - If both valids are high, grant the requester named by the priority pointer `prio`.
  - On a grant: assert `reqN_ready` for the granted requester only (combinational, same cycle), latch op, a, b and the grant index `gnt`, then go to EXEC.
- **EXEC:** the ALU sees the latched op/a/b. Register `ALUResult` and `Zero` into `res_q`/`zero_q`, then go to RESP.
- **RESP:**
  - Assert `rsp{gnt}_valid`. The other `rsp*_valid` stays 0.
  - Hold in RESP until `rsp{gnt}_ready` is 1.
  - On acceptance: set `prio` to the other requester, then go to IDLE.
- `rspN_result` and `rspN_zero` both present `res_q` and `zero_q`. Their value is only meaningful while `rspN_valid` is 1.
- `Zero` is 1 only for SUB with equal operands. It is 0 for AND/OR/ADD, even when the result is 0; this is passed through unchanged.
- Arithmetic wraps modulo 2^32. There is no carry or overflow output.
- **Requester rules:**
  - Requesters hold valid, op, a and b stable until ready.
  - A requester may drop valid before it is granted; nothing is recorded.
  - `rspN_ready` is ignored outside RESP, and ignored for the non-granted requester.
- While the block is in EXEC or RESP, both `reqN_ready` are 0. New requests wait and are not queued.
- **Reset:** asserting `rst_n` low at any time immediately forces the following. An in-flight operation is discarded and no response is produced.
  - state = IDLE
  - `prio` = `RR_INIT`
  - `gnt` = 0
  - `res_q` = 0, `zero_q` = 0
  - all ready and valid outputs = 0

## Timing
- A request is accepted in cycle t, with valid and ready both high. `rsp_valid` rises in cycle t+2.
- Best-case throughput is one operation per 3 cycles, when `rsp_ready` is already high in t+2.
- Back-to-back sequence: accept in t, response accepted in t+2, IDLE in t+3, next accept in t+3.
- `reqN_ready` is a combinational function of state, `prio` and both valids. It has no path from `rspN_ready`.
- `rspN_valid`, `rspN_result` and `rspN_zero` are driven directly from registers.
- Fairness: when both requesters are continuously valid, grants strictly alternate. Neither requester waits more than one full operation of the other.

## Structure
- Shared package `alu_pkg`:
  - op constants `ALU_AND`=2'b00, `ALU_OR`=2'b01, `ALU_ADD`=2'b10, `ALU_SUB`=2'b11
  - FSM state encoding IDLE/EXEC/RESP
- One sub-module: the existing `ALU`, instantiated once and fed from the latched op/a/b registers.
- The grant logic is small and stays inline; there is no separate arbiter module.

## Test plan
- After reset, `req0_valid`=1, op=ADD, a=5, b=7 → `req0_ready` high in cycle 0. `rsp0_valid` high in cycle 2 with result=12, zero=0.
- req1 SUB, a=b=0x1234 → `rsp1_result`=0, `rsp1_zero`=1. Then req1 AND, 0xF0F0 & 0x0F0F → result=0, zero=0.
- Both valid every cycle, `RR_INIT`=0, `rsp_ready` tied high → grant order is 0,1,0,1. Each accept is 3 cycles apart, and no ready is asserted for the loser.
- `rsp0_ready` held low for 5 cycles → `rsp0_valid` and result stay stable. `req1_ready` stays 0 throughout; req1 is granted in the cycle after `rsp0_ready` rises.
- Reset asserted during EXEC → all outputs are 0 immediately, and no response appears after release. The next request uses `prio`=`RR_INIT`.
- ADD 0xFFFFFFFF + 1 → result=0, zero=0. SUB 0 − 1 → result=0xFFFFFFFF, zero=0.
